// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width and Gray helpers
// used by both the write-side and read-side pointer handlers.
package fifo_pkg;

  localparam int PTR_WIDTH = 3;
  localparam int PTR_MAX   = 16;

  typedef logic [PTR_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_handler_if.sv
// Producer/memory-side bundle of the write pointer handler.
// master = producer side, slave = the handler itself.
interface wptr_handler_if
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH
);

  logic                 w_en;
  logic [PTR_WIDTH:0]   g_rptr;
  logic                 ovf_clr;
  logic                 wr_ok;
  logic [PTR_WIDTH-1:0] waddr;
  logic [PTR_WIDTH:0]   b_wptr;
  logic [PTR_WIDTH:0]   g_wptr;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH:0]   wfill;
  logic                 overflow;

  modport master (
    output w_en, g_rptr, ovf_clr,
    input  wr_ok, waddr, b_wptr, g_wptr,
    input  full, almost_full, wfill, overflow
  );

  modport slave (
    input  w_en, g_rptr, ovf_clr,
    output wr_ok, waddr, b_wptr, g_wptr,
    output full, almost_full, wfill, overflow
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with async active-low reset.
// Shared by both pointer handlers for the crossing Gray pointer.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_d, s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/wptr_handler.sv
// Write-side pointer/flag engine of the async FIFO (wclk domain).
// Flags use a synchronised, possibly stale read pointer: pessimistic only.
module wptr_handler
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH,
  parameter int AF_LEVEL  = 6
) (
  input  logic           wclk,
  input  logic           wrst_n,
  wptr_handler_if.slave  bus
);

  localparam int PW = PTR_WIDTH;

  typedef logic [PW:0] wp_t;

  wp_t  g_rptr_sync;
  wp_t  rbin;
  wp_t  b_wptr_d, b_wptr_q;
  wp_t  g_wptr_d, g_wptr_q;
  wp_t  wfill_d, wfill_q;
  logic full_d, full_q;
  logic af_d, af_q;
  logic ovf_d, ovf_q;
  logic accept;

  sync_2ff #(
    .WIDTH (PW + 1)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (bus.g_rptr),
    .q     (g_rptr_sync)
  );

  assign accept = bus.w_en & ~full_q;

  always_comb begin
    b_wptr_d = b_wptr_q + wp_t'(accept);
    g_wptr_d = wp_t'(bin2gray(ptr_t'(b_wptr_d)));
    rbin     = wp_t'(gray2bin(ptr_t'(g_rptr_sync)));
    wfill_d  = b_wptr_d - rbin;
    // Full: same lap position, opposite wrap parity (top two Gray bits flip).
    full_d   = g_wptr_d ==
               {~g_rptr_sync[PW:PW-1], g_rptr_sync[PW-2:0]};
    af_d     = int'(wfill_d) >= AF_LEVEL;
    ovf_d    = (bus.w_en & full_q) | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      wfill_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      wfill_q  <= wfill_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.wr_ok       = accept;
  assign bus.waddr       = b_wptr_q[PW-1:0];
  assign bus.b_wptr      = b_wptr_q;
  assign bus.g_wptr      = g_wptr_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.wfill       = wfill_q;
  assign bus.overflow    = ovf_q;

endmodule
